// File: rtl/serial_test_pkg.sv
// Shared definitions for the increment-echo link: state encodings, the
// default baud constant and the echo rule both link ends agree on.
package serial_test_pkg;

  localparam int CLK_TICKS_PER_RS232_BIT = 434;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_SEND    = 4'd1;
  localparam logic [3:0] ST_TX_WAIT = 4'd2;
  localparam logic [3:0] ST_RX_WAIT = 4'd3;
  localparam logic [3:0] ST_RX_READ = 4'd4;
  localparam logic [3:0] ST_CHECK   = 4'd5;
  localparam logic [3:0] ST_NEXT    = 4'd6;
  localparam logic [3:0] ST_DONE    = 4'd7;

  typedef enum logic [3:0] {
    S_IDLE    = ST_IDLE,
    S_SEND    = ST_SEND,
    S_TX_WAIT = ST_TX_WAIT,
    S_RX_WAIT = ST_RX_WAIT,
    S_RX_READ = ST_RX_READ,
    S_CHECK   = ST_CHECK,
    S_NEXT    = ST_NEXT,
    S_DONE    = ST_DONE
  } state_e;

  // The far end answers every byte with its successor, wrapping at 8 bits.
  function automatic logic [7:0] echo_expected(input logic [7:0] b);
    return b + 8'd1;
  endfunction

  // Error counter increment that sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/serial_echo_tester_if.sv
// Byte-level link between the echo tester and its quick_rs232 instance.
interface serial_echo_tester_if;
  logic       tx_transaction;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       tx_data_copied;
  logic       tx_busy;
  logic       rx_byte_received;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       rx_read;

  modport master (
    output tx_transaction, tx_data, tx_data_ready, rx_read,
    input  tx_data_copied, tx_busy, rx_byte_received, rx_data, rx_err
  );

  modport slave (
    input  tx_transaction, tx_data, tx_data_ready, rx_read,
    output tx_data_copied, tx_busy, rx_byte_received, rx_data, rx_err
  );
endinterface

// File: rtl/serial_echo_tester_rise_detect.sv
// Registered rising-edge detector for the receiver's byte-received flag.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  // Keep last cycle's sample so a 0->1 step can be recognised.
  // NOTE: flops use non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) r_prev <= 1'b0;
    else      r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/serial_echo_tester.sv
// Host-side initiator for the increment-echo link: sends BYTE_COUNT bytes,
// waits for each echo, checks it against sent+1 and reports a verdict.
module serial_echo_tester
  import serial_test_pkg::*;
#(
  parameter int         BYTE_COUNT     = 16,
  parameter logic [7:0] START_BYTE     = 8'h00,
  parameter int         TIMEOUT_CYCLES = 2000000,
  parameter int         RX_READ_CYCLES = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           err_count,
  output logic [7:0]           last_rx,
  serial_echo_tester_if.master bus
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CNT_W   = (RX_READ_CYCLES > 2) ? $clog2(RX_READ_CYCLES) : 1;

  state_e               r_state,          w_state;
  logic [8:0]           r_idx,            w_idx;
  logic [TIMER_W-1:0]   r_timer,          w_timer;
  logic [CNT_W-1:0]     r_cnt,            w_cnt;
  logic [7:0]           r_err_count,      w_err_count;
  logic [7:0]           r_last_rx,        w_last_rx;
  logic [7:0]           r_tx_data,        w_tx_data;
  logic                 r_pass,           w_pass;
  logic                 r_done,           w_done;
  logic                 r_busy,           w_busy;
  logic                 r_rx_err,         w_rx_err;
  logic                 r_tx_transaction, w_tx_transaction;
  logic                 r_tx_data_ready,  w_tx_data_ready;
  logic                 r_rx_read,        w_rx_read;
  logic                 r_rx_pending,     w_rx_pending;
  logic                 w_rx_rise;

  rise_detect u_rise_detect (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (bus.rx_byte_received),
    .o_rise (w_rx_rise)
  );

  // State and datapath registers; reset clears everything and aborts a run.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= S_IDLE;
      r_idx            <= '0;
      r_timer          <= '0;
      r_cnt            <= '0;
      r_err_count      <= '0;
      r_last_rx        <= '0;
      r_tx_data        <= '0;
      r_pass           <= 1'b0;
      r_done           <= 1'b0;
      r_busy           <= 1'b0;
      r_rx_err         <= 1'b0;
      r_tx_transaction <= 1'b0;
      r_tx_data_ready  <= 1'b0;
      r_rx_read        <= 1'b0;
      r_rx_pending     <= 1'b0;
    end else begin
      r_state          <= w_state;
      r_idx            <= w_idx;
      r_timer          <= w_timer;
      r_cnt            <= w_cnt;
      r_err_count      <= w_err_count;
      r_last_rx        <= w_last_rx;
      r_tx_data        <= w_tx_data;
      r_pass           <= w_pass;
      r_done           <= w_done;
      r_busy           <= w_busy;
      r_rx_err         <= w_rx_err;
      r_tx_transaction <= w_tx_transaction;
      r_tx_data_ready  <= w_tx_data_ready;
      r_rx_read        <= w_rx_read;
      r_rx_pending     <= w_rx_pending;
    end
  end

  // Next-state and next-output logic for the send/wait/read/check sequence.
  always_comb begin
    // NOTE: every w_ signal starts from its held value so no branch infers a latch.
    w_state          = r_state;
    w_idx            = r_idx;
    w_timer          = r_timer;
    w_cnt            = r_cnt;
    w_err_count      = r_err_count;
    w_last_rx        = r_last_rx;
    w_tx_data        = r_tx_data;
    w_pass           = r_pass;
    w_done           = r_done;
    w_busy           = r_busy;
    w_rx_err         = r_rx_err;
    w_tx_transaction = r_tx_transaction;
    w_tx_data_ready  = r_tx_data_ready;
    w_rx_read        = r_rx_read;
    w_rx_pending     = r_rx_pending;

    // An echo may land while still sending; remember it until it is read.
    if (w_rx_rise && (r_state != S_IDLE)) w_rx_pending = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state          = S_SEND;
          w_busy           = 1'b1;
          w_err_count      = '0;
          w_pass           = 1'b0;
          w_idx            = '0;
          w_tx_data        = START_BYTE;
          w_tx_transaction = 1'b1;
          w_tx_data_ready  = 1'b1;
          w_rx_pending     = 1'b0;
        end
      end
      S_SEND: begin
        if (bus.tx_data_copied) begin
          w_tx_data_ready = 1'b0;
          w_state         = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (!bus.tx_busy) begin
          w_tx_transaction = 1'b0;
          w_timer          = '0;
          w_state          = S_RX_WAIT;
        end
      end
      S_RX_WAIT: begin
        // A pending reply takes priority over an expiring timer.
        if (r_rx_pending) begin
          w_rx_pending = 1'b0;
          w_rx_read    = 1'b1;
          w_cnt        = '0;
          w_state      = S_RX_READ;
        end else if (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          w_err_count = sat_inc8(r_err_count);
          w_state     = S_NEXT;
        end else begin
          w_timer = r_timer + TIMER_W'(1);
        end
      end
      S_RX_READ: begin
        if (r_cnt == CNT_W'(RX_READ_CYCLES - 1)) begin
          w_last_rx = bus.rx_data;
          w_rx_err  = bus.rx_err;
          w_rx_read = 1'b0;
          w_state   = S_CHECK;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (r_rx_err || (r_last_rx != echo_expected(START_BYTE + r_idx[7:0])))
          w_err_count = sat_inc8(r_err_count);
        w_state = S_NEXT;
      end
      S_NEXT: begin
        if (r_idx == 9'(BYTE_COUNT - 1)) begin
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_pass  = (r_err_count == 8'd0);
          w_state = S_DONE;
        end else begin
          w_idx            = r_idx + 9'd1;
          w_tx_data        = START_BYTE + r_idx[7:0] + 8'd1;
          w_tx_transaction = 1'b1;
          w_tx_data_ready  = 1'b1;
          w_state          = S_SEND;
        end
      end
      S_DONE: begin
        w_done  = 1'b0;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign busy               = r_busy;
  assign done               = r_done;
  assign pass               = r_pass;
  assign err_count          = r_err_count;
  assign last_rx            = r_last_rx;
  assign bus.tx_transaction = r_tx_transaction;
  assign bus.tx_data        = r_tx_data;
  assign bus.tx_data_ready  = r_tx_data_ready;
  assign bus.rx_read        = r_rx_read;

endmodule

// File: tb/tb_serial_echo_tester.sv
// Self-checking bench: three tester instances with different parameters,
// driven one at a time by a behavioural far-end (quick_rs232 + echo board).
module tb_serial_echo_tester;

  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       start_b = 1'b0;
  logic       b_copied = 1'b0, b_txbusy = 1'b0, b_rxrecv = 1'b0, b_rxerr = 1'b0;
  logic [7:0] b_rxdata = 8'h00;
  int         sel = 0;

  logic       busy_v [3], done_v [3], pass_v [3];
  logic [7:0] err_v [3], last_v [3];
  logic       start_v [3], tdr_v [3], txn_v [3], rxr_v [3];
  logic [7:0] txd_v [3];

  // Behavioural model parameters, one entry per instance.
  int p_start [3] = '{8'h10, 8'hFE, 8'h80};
  int p_count [3] = '{4, 2, 256};
  int p_read  [3] = '{3, 1, 2};
  int exp_last [3] = '{0, 0, 0};

  int n_checks = 0;
  int n_errors = 0;

  serial_echo_tester_if ifs [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_link
    assign ifs[g].tx_data_copied   = (sel == g) ? b_copied : 1'b0;
    assign ifs[g].tx_busy          = (sel == g) ? b_txbusy : 1'b0;
    assign ifs[g].rx_byte_received = (sel == g) ? b_rxrecv : 1'b0;
    assign ifs[g].rx_data          = (sel == g) ? b_rxdata : 8'h00;
    assign ifs[g].rx_err           = (sel == g) ? b_rxerr  : 1'b0;
    assign start_v[g]              = (sel == g) ? start_b  : 1'b0;
    assign tdr_v[g]                = ifs[g].tx_data_ready;
    assign txn_v[g]                = ifs[g].tx_transaction;
    assign txd_v[g]                = ifs[g].tx_data;
    assign rxr_v[g]                = ifs[g].rx_read;
  end

  serial_echo_tester #(.BYTE_COUNT(4), .START_BYTE(8'h10), .TIMEOUT_CYCLES(TIMEOUT), .RX_READ_CYCLES(3))
  u_dut_a (.clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
           .pass(pass_v[0]), .err_count(err_v[0]), .last_rx(last_v[0]), .bus(ifs[0]));

  serial_echo_tester #(.BYTE_COUNT(2), .START_BYTE(8'hFE), .TIMEOUT_CYCLES(TIMEOUT), .RX_READ_CYCLES(1))
  u_dut_b (.clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
           .pass(pass_v[1]), .err_count(err_v[1]), .last_rx(last_v[1]), .bus(ifs[1]));

  serial_echo_tester #(.BYTE_COUNT(256), .START_BYTE(8'h80), .TIMEOUT_CYCLES(TIMEOUT), .RX_READ_CYCLES(2))
  u_dut_c (.clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
           .pass(pass_v[2]), .err_count(err_v[2]), .last_rx(last_v[2]), .bus(ifs[2]));

  // Independent event counters for the selected instance.
  int   tdr_rises = 0, done_seen = 0;
  logic tdr_prev = 1'b0;
  always @(negedge clk) begin
    if (tdr_v[sel] === 1'b1 && tdr_prev !== 1'b1) tdr_rises++;
    tdr_prev = tdr_v[sel];
    if (done_v[sel] === 1'b1) done_seen++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reply plan for the next run, one entry per byte.
  logic [7:0] rp_data   [256];
  bit         rp_err    [256];
  bit         rp_silent [256];
  bit         rp_early  [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] sent_byte(input int i);
    return 8'((p_start[sel] + i) % 256);
  endfunction

  function automatic logic [7:0] exp_reply(input int i);
    return 8'((p_start[sel] + i + 1) % 256);
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0:       return tdr_v[sel];
      1:       return rxr_v[sel];
      default: return done_v[sel];
    endcase
  endfunction

  task automatic wait_until(input string tag, input int which, input int budget, output bit ok);
    int n = 0;
    while (sig(which) !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    ok = (sig(which) === 1'b1);
    if (!ok) check({tag, "/wait"}, sig(which), 1);
  endtask

  task automatic recover();
    b_copied = 1'b0; b_txbusy = 1'b0; b_rxrecv = 1'b0; b_rxerr = 1'b0; start_b = 1'b0;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    for (int g = 0; g < 3; g++) exp_last[g] = 0;
  endtask

  task automatic drive_reply(input int i);
    b_rxdata = rp_data[i];
    b_rxerr  = rp_err[i];
    b_rxrecv = 1'b1;
  endtask

  task automatic plan_good();
    for (int i = 0; i < 256; i++) begin
      rp_data[i]   = exp_reply(i);
      rp_err[i]    = 1'b0;
      rp_silent[i] = 1'b0;
      rp_early[i]  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic plan_random();
    plan_good();
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 4))
        1: rp_data[i]   = exp_reply(i) ^ 8'($urandom_range(1, 255));
        2: rp_err[i]    = 1'b1;
        3: rp_silent[i] = 1'b1;
        default: ;
      endcase
    end
  endtask

  // One complete run on the selected instance with the current reply plan.
  task automatic run(input string tag, input bit poke);
    int n, d, cnt, tdr0, done0, e_err, e_last;
    bit ok;
    n = p_count[sel]; tdr0 = tdr_rises; done0 = done_seen;
    e_err = 0; e_last = exp_last[sel];
    for (int i = 0; i < n; i++) begin
      if (rp_silent[i] || rp_err[i] || rp_data[i] != exp_reply(i)) e_err++;
      if (!rp_silent[i]) e_last = int'(rp_data[i]);
    end
    if (e_err > 255) e_err = 255;

    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    check({tag, "/busy_on"}, busy_v[sel], 1);
    check({tag, "/txn_on"}, txn_v[sel], 1);

    for (int i = 0; i < n; i++) begin
      wait_until($sformatf("%s/b%0d/tdr", tag, i), 0, 400, ok);
      if (!ok) begin recover(); return; end
      check($sformatf("%s/b%0d/txd", tag, i), txd_v[sel], sent_byte(i));
      check($sformatf("%s/b%0d/txn", tag, i), txn_v[sel], 1);
      d = (poke && i == 1) ? $urandom_range(1, 3) : $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        if (poke && i == 1) start_b = 1'b1;
        step(1);
      end
      start_b = 1'b0;
      check($sformatf("%s/b%0d/txd_hold", tag, i), txd_v[sel], sent_byte(i));
      b_copied = 1'b1;
      step(1);
      b_copied = 1'b0;
      check($sformatf("%s/b%0d/tdr_off", tag, i), tdr_v[sel], 0);
      b_txbusy = 1'b1;
      if (rp_early[i] && !rp_silent[i]) begin
        step(1);
        drive_reply(i);
      end
      step($urandom_range(1, 4));
      b_txbusy = 1'b0;
      if (!rp_silent[i]) begin
        if (!rp_early[i]) begin
          step($urandom_range(0, 5));
          drive_reply(i);
        end
        wait_until($sformatf("%s/b%0d/rx_read", tag, i), 1, 200, ok);
        if (!ok) begin recover(); return; end
        b_rxrecv = 1'b0;
        cnt = 0;
        while (rxr_v[sel] === 1'b1 && cnt < 64) begin
          cnt++;
          step(1);
        end
        check($sformatf("%s/b%0d/rd_len", tag, i), cnt, p_read[sel]);
        b_rxdata = 8'($urandom);
        b_rxerr  = 1'b0;
      end
    end

    wait_until({tag, "/done"}, 2, 400, ok);
    if (!ok) begin recover(); return; end
    check({tag, "/pass"}, pass_v[sel], (e_err == 0) ? 1 : 0);
    check({tag, "/err_count"}, err_v[sel], e_err);
    check({tag, "/last_rx"}, last_v[sel], e_last);
    check({tag, "/busy_off"}, busy_v[sel], 0);
    exp_last[sel] = e_last;
    step(1);
    check({tag, "/done_1cyc"}, done_v[sel], 0);
    check({tag, "/tdr_count"}, tdr_rises - tdr0, n);
    check({tag, "/done_count"}, done_seen - done0, 1);
  endtask

  initial begin
    int d0;
    // Reset state of every instance.
    step(3);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst/busy%0d", g), busy_v[g], 0);
      check($sformatf("rst/done%0d", g), done_v[g], 0);
      check($sformatf("rst/pass%0d", g), pass_v[g], 0);
      check($sformatf("rst/err%0d", g), err_v[g], 0);
      check($sformatf("rst/last%0d", g), last_v[g], 0);
      check($sformatf("rst/tdr%0d", g), tdr_v[g], 0);
      check($sformatf("rst/txn%0d", g), txn_v[g], 0);
      check($sformatf("rst/txd%0d", g), txd_v[g], 0);
      check($sformatf("rst/rxr%0d", g), rxr_v[g], 0);
    end
    rst = 1'b1;
    step(2);

    // Instance A: good echo, start poked mid-run.
    sel = 0;
    plan_good();
    run("a_good", 1'b1);

    // Early reply, timeout, rx_err with correct data, wrong data.
    plan_good();
    rp_early[0]  = 1'b1;
    rp_silent[1] = 1'b1;
    rp_err[2]    = 1'b1;
    rp_data[3]   = exp_reply(3) ^ 8'h5A;
    run("a_mixed", 1'b0);

    for (int r = 0; r < 4; r++) begin
      plan_random();
      run($sformatf("a_rand%0d", r), 1'b0);
    end

    // Instance B: wrap-around FE, FF -> FF, 00.
    sel = 1;
    step(2);
    plan_good();
    run("b_wrap_good", 1'b0);
    plan_good();
    rp_data[0] = 8'h00;
    run("b_wrap_bad", 1'b0);

    // Instance C: 256 bytes, every reply wrong -> counter saturates.
    sel = 2;
    step(2);
    plan_good();
    for (int i = 0; i < 256; i++) rp_data[i] = exp_reply(i) ^ 8'($urandom_range(1, 255));
    run("c_saturate", 1'b0);

    // Instance A: reset in the middle of SEND aborts without done.
    sel = 0;
    step(2);
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    check("mid_rst/tdr_before", tdr_v[0], 1);
    step(2);
    d0 = done_seen;
    rst = 1'b0;
    step(1);
    check("mid_rst/tdr", tdr_v[0], 0);
    check("mid_rst/txn", txn_v[0], 0);
    check("mid_rst/busy", busy_v[0], 0);
    check("mid_rst/done", done_v[0], 0);
    check("mid_rst/last", last_v[0], 0);
    rst = 1'b1;
    for (int g = 0; g < 3; g++) exp_last[g] = 0;
    step(10);
    check("mid_rst/no_done", done_seen - d0, 0);
    check("mid_rst/idle_tdr", tdr_v[0], 0);

    plan_good();
    run("a_after_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
